// File: rtl/max7219_spi_tx_pkg.sv
// Shared definitions for the MAX7219 serial transmit path: register map,
// frame layout, phase markers and FSM state encoding.
package max7219_spi_tx_pkg;

    localparam int FRAME_W = 16;

    localparam logic [3:0] REG_NOOP       = 4'h0;
    localparam logic [3:0] REG_DIGIT0     = 4'h1;
    localparam logic [3:0] REG_DIGIT1     = 4'h2;
    localparam logic [3:0] REG_DIGIT2     = 4'h3;
    localparam logic [3:0] REG_DIGIT3     = 4'h4;
    localparam logic [3:0] REG_DIGIT4     = 4'h5;
    localparam logic [3:0] REG_DIGIT5     = 4'h6;
    localparam logic [3:0] REG_DIGIT6     = 4'h7;
    localparam logic [3:0] REG_DIGIT7     = 4'h8;
    localparam logic [3:0] REG_DECODE     = 4'h9;
    localparam logic [3:0] REG_INTENSITY  = 4'hA;
    localparam logic [3:0] REG_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN   = 4'hC;
    localparam logic [3:0] REG_TEST       = 4'hF;

    // Phases 1..32 alternate HIGH/LOW serial clock; phase 33 raises LOAD.
    localparam logic [5:0] PHASE_LATCH = 6'd33;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_LATCH,
        ST_ACK
    } state_t;

    function automatic int tick_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0] addr,
                                                       input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

endpackage

// File: rtl/max7219_tick_div.sv
// Half-period tick generator: o_tick is high on the last cycle of every
// DIV-cycle phase; i_restart begins a fresh phase on the next cycle.
module max7219_tick_div
    import max7219_spi_tx_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int              W    = tick_width(DIV);
    localparam logic [W-1:0]    LAST = W'(DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (i_restart || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign o_tick = (count == LAST);

endmodule

// File: rtl/max7219_spi_tx.sv
// MAX7219 serial transmitter: shifts one {4'h0,addr,data} frame MSB first on
// DOUT/CLK and latches it with a rising LOAD, then pulses o_ack for one cycle.
module max7219_spi_tx
    import max7219_spi_tx_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_stb,
    output logic       o_busy,
    output logic       o_ack,
    input  logic [3:0] i_addr,
    input  logic [7:0] i_data,
    output logic       o_serial_dout,
    output logic       o_serial_load,
    output logic       o_serial_clk
);

    state_t               state;
    state_t               state_n;
    logic [5:0]           phase;
    logic [5:0]           phase_n;
    logic [5:0]           phase_inc;
    logic [FRAME_W-1:0]   sr;
    logic [FRAME_W-1:0]   sr_n;
    logic [FRAME_W-1:0]   shifted;
    logic [FRAME_W-1:0]   frame;
    logic                 load_n;
    logic                 sclk_n;
    logic                 dout_n;
    logic                 accept;
    logic                 tick;

    assign frame     = build_frame(i_addr, i_data);
    assign shifted   = {sr[FRAME_W-2:0], 1'b0};
    assign phase_inc = phase + 6'd1;

    max7219_tick_div #(
        .DIV (CLK_DIV)
    ) u_tick_div (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_restart (accept),
        .o_tick    (tick)
    );

    // Serial pins are registered so the MAX7219 never sees decode glitches.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            phase         <= '0;
            sr            <= '0;
            o_serial_load <= 1'b1;
            o_serial_clk  <= 1'b0;
            o_serial_dout <= 1'b0;
        end else begin
            state         <= state_n;
            phase         <= phase_n;
            sr            <= sr_n;
            o_serial_load <= load_n;
            o_serial_clk  <= sclk_n;
            o_serial_dout <= dout_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        sr_n    = sr;
        load_n  = o_serial_load;
        sclk_n  = o_serial_clk;
        dout_n  = o_serial_dout;
        accept  = 1'b0;

        case (state)
            // ACK accepts like IDLE so the sequencer can stream frames back to back.
            ST_IDLE, ST_ACK: begin
                state_n = ST_IDLE;
                load_n  = 1'b1;
                sclk_n  = 1'b0;
                dout_n  = 1'b0;
                if (i_stb) begin
                    accept  = 1'b1;
                    state_n = ST_START;
                    phase_n = '0;
                    sr_n    = frame;
                    load_n  = 1'b0;
                    dout_n  = frame[FRAME_W-1];
                end
            end
            ST_START, ST_SHIFT: begin
                if (tick) begin
                    phase_n = phase_inc;
                    if (phase_inc == PHASE_LATCH) begin
                        state_n = ST_LATCH;
                        load_n  = 1'b1;
                        sclk_n  = 1'b0;
                        dout_n  = 1'b0;
                    end else begin
                        state_n = ST_SHIFT;
                        sclk_n  = phase_inc[0];
                        if (!phase_inc[0]) begin
                            sr_n   = shifted;
                            dout_n = shifted[FRAME_W-1];
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    state_n = ST_ACK;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign o_busy = (state == ST_START) || (state == ST_SHIFT) || (state == ST_LATCH);
    assign o_ack  = (state == ST_ACK);

endmodule

// File: tb/tb_max7219_spi_tx.sv
// Bench for max7219_spi_tx: two instances (CLK_DIV=2 and 1) checked every cycle
// against an elapsed-time frame model, plus a MAX7219 receiver that decodes frames.
module tb_max7219_spi_tx;
    import max7219_spi_tx_pkg::*;

    localparam int DIV0 = 2;
    localparam int DIV1 = 1;

    logic            clk  = 1'b0;
    logic            rst  = 1'b0;
    logic [1:0]      stb  = '0;
    logic [1:0][3:0] addr = '0;
    logic [1:0][7:0] data = '0;
    logic [1:0]      busy;
    logic [1:0]      ack;
    logic [1:0]      dout;
    logic [1:0]      load;
    logic [1:0]      sclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit          act  [2];
    int          e0   [2];
    logic [15:0] word [2];

    always #5 clk = ~clk;

    max7219_spi_tx #(.CLK_DIV(DIV0)) u_dut0 (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_stb         (stb[0]),
        .o_busy        (busy[0]),
        .o_ack         (ack[0]),
        .i_addr        (addr[0]),
        .i_data        (data[0]),
        .o_serial_dout (dout[0]),
        .o_serial_load (load[0]),
        .o_serial_clk  (sclk[0])
    );

    max7219_spi_tx #(.CLK_DIV(DIV1)) u_dut1 (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_stb         (stb[1]),
        .o_busy        (busy[1]),
        .o_ack         (ack[1]),
        .i_addr        (addr[1]),
        .i_data        (data[1]),
        .o_serial_dout (dout[1]),
        .o_serial_load (load[1]),
        .o_serial_clk  (sclk[1])
    );

    function automatic int divOf(input int g);
        return (g == 0) ? DIV0 : DIV1;
    endfunction

    // Expected {busy, ack, load, clk, dout} a given number of cycles after accept.
    function automatic logic [4:0] modelOut(input int d, input bit active, input int el,
                                            input logic [15:0] w);
        int k;
        int j;
        if (!active) return 5'b00100;
        if (el >= 34 * d) return 5'b01100;
        k = el / d;
        if (k == 0) return {1'b1, 1'b0, 1'b0, 1'b0, w[15]};
        if (k <= 32) begin
            j = k / 2;
            return {1'b1, 1'b0, 1'b0, (k % 2 == 1), (j < 16) ? w[15 - j] : 1'b0};
        end
        return 5'b10100;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Model: track accept edge and word per instance; a frame ends after its ack cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act[0] = 1'b0;
            act[1] = 1'b0;
        end else begin
            cyc++;
            for (int g = 0; g < 2; g++) begin
                if (act[g] && (cyc - 1 - e0[g]) >= 34 * divOf(g)) act[g] = 1'b0;
                if (!act[g] && stb[g]) begin
                    act[g]  = 1'b1;
                    e0[g]   = cyc;
                    word[g] = {4'h0, addr[g], data[g]};
                end
            end
        end
    end

    logic [1:0] prev_load;
    logic [1:0] prev_sclk;
    logic [1:0] prev_dout;
    bit         prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                checkOutput($sformatf("inst%0d_outputs_cyc%0d", g, cyc),
                            {busy[g], ack[g], load[g], sclk[g], dout[g]},
                            modelOut(divOf(g), act[g], cyc - e0[g], word[g]));
                if (prev_valid && (load[g] !== prev_load[g]))
                    checkOutput($sformatf("inst%0d_load_edge_clk_cyc%0d", g, cyc),
                                {prev_sclk[g], sclk[g]}, 0);
                if (prev_valid && (dout[g] !== prev_dout[g]))
                    checkOutput($sformatf("inst%0d_dout_edge_clk_cyc%0d", g, cyc), sclk[g], 0);
            end
            prev_valid = 1'b1;
        end
        prev_load = load;
        prev_sclk = sclk;
        prev_dout = dout;
    end

    // MAX7219 receiver: shift DIN on CLK rise, latch register on LOAD rise.
    for (genvar g = 0; g < 2; g++) begin : g_rx
        logic [15:0] sh = '0;
        logic [7:0]  regs [16];
        int          rise_cyc[$];
        int          load_cyc[$];
        int          rises_at_load[$];
        logic [15:0] latched_q[$];
        int          ack_cyc[$];

        always @(posedge sclk[g]) begin
            rise_cyc.push_back(cyc);
            sh = {sh[14:0], dout[g]};
        end

        always @(posedge load[g]) begin
            latched_q.push_back(sh);
            load_cyc.push_back(cyc);
            rises_at_load.push_back(rise_cyc.size());
            regs[sh[11:8]] = sh[7:0];
        end

        always @(negedge clk) begin
            if (!rst && ack[g]) ack_cyc.push_back(cyc);
        end
    end

    function automatic int ackCount(input int g);
        return (g == 0) ? g_rx[0].ack_cyc.size() : g_rx[1].ack_cyc.size();
    endfunction

    task automatic applyStimulus(input int g, input logic [3:0] a, input logic [7:0] d,
                                 output int e_out);
        @(negedge clk);
        stb[g]  = 1'b1;
        addr[g] = a;
        data[g] = d;
        @(posedge clk);
        #1;
        e_out = cyc;
        @(negedge clk);
        stb[g] = 1'b0;
    endtask

    task automatic waitAcks(input int g, input int target, input int budget, input string name);
        int n = 0;
        while (ackCount(g) < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(name, ackCount(g) >= target, 1);
    endtask

    initial begin
        int e;
        int l0;
        int r0;
        int a0;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_inst0", {busy[0], ack[0], load[0], sclk[0], dout[0]}, 5'b00100);
        checkOutput("reset_inst1", {busy[1], ack[1], load[1], sclk[1], dout[1]}, 5'b00100);
        @(negedge clk);
        rst = 1'b0;

        // Single frame 0x015A at CLK_DIV=2 with pinned edge timing.
        l0 = g_rx[0].load_cyc.size();
        r0 = g_rx[0].rise_cyc.size();
        a0 = g_rx[0].ack_cyc.size();
        applyStimulus(0, REG_DIGIT0, 8'h5A, e);
        checkOutput("t2_load_low_after_E0", load[0], 0);
        checkOutput("t2_busy_after_E0", busy[0], 1);
        waitAcks(0, a0 + 1, 100, "t2_ack_wait");
        repeat (4) @(negedge clk);
        checkOutput("t2_ack_count", g_rx[0].ack_cyc.size() - a0, 1);
        if (g_rx[0].ack_cyc.size() > a0) checkOutput("t2_ack_cycle", g_rx[0].ack_cyc[a0], e + 68);
        checkOutput("t2_rise_count", g_rx[0].rise_cyc.size() - r0, 16);
        if (g_rx[0].rise_cyc.size() > r0) checkOutput("t2_first_rise", g_rx[0].rise_cyc[r0], e + 2);
        checkOutput("t2_load_count", g_rx[0].load_cyc.size() - l0, 1);
        if (g_rx[0].load_cyc.size() > l0) begin
            checkOutput("t2_load_rise", g_rx[0].load_cyc[l0], e + 66);
            checkOutput("t2_word", g_rx[0].latched_q[l0], 16'h015A);
        end

        // Reset asserted between edges while idle.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t1_idle_reset_inst0", {busy[0], ack[0], load[0], sclk[0], dout[0]}, 5'b00100);
        checkOutput("t1_idle_reset_inst1", {busy[1], ack[1], load[1], sclk[1], dout[1]}, 5'b00100);
        @(negedge clk);
        rst = 1'b0;

        // Strobe at E0+10 with a different word must be ignored.
        l0 = g_rx[0].load_cyc.size();
        r0 = g_rx[0].rise_cyc.size();
        a0 = g_rx[0].ack_cyc.size();
        applyStimulus(0, REG_SHUTDOWN, 8'h01, e);
        repeat (9) @(negedge clk);
        stb[0]  = 1'b1;
        addr[0] = 4'h3;
        data[0] = 8'hFF;
        @(negedge clk);
        stb[0] = 1'b0;
        waitAcks(0, a0 + 1, 100, "t4_ack_wait");
        repeat (6) @(negedge clk);
        checkOutput("t4_ack_count", g_rx[0].ack_cyc.size() - a0, 1);
        checkOutput("t4_load_count", g_rx[0].load_cyc.size() - l0, 1);
        checkOutput("t4_rise_count", g_rx[0].rise_cyc.size() - r0, 16);
        if (g_rx[0].load_cyc.size() > l0) checkOutput("t4_word", g_rx[0].latched_q[l0], 16'h0C01);
        checkOutput("t5_shutdown_reg", g_rx[0].regs[12], 8'h01);

        l0 = g_rx[0].load_cyc.size();
        a0 = g_rx[0].ack_cyc.size();
        applyStimulus(0, REG_TEST, 8'h00, e);
        waitAcks(0, a0 + 1, 100, "t5_ack_wait");
        repeat (2) @(negedge clk);
        if (g_rx[0].load_cyc.size() > l0) checkOutput("t5_word", g_rx[0].latched_q[l0], 16'h0F00);
        checkOutput("t5_test_reg", g_rx[0].regs[15], 8'h00);

        // Held strobe at CLK_DIV=1: back-to-back frames, acks 35 cycles apart.
        l0 = g_rx[1].load_cyc.size();
        r0 = g_rx[1].rise_cyc.size();
        a0 = g_rx[1].ack_cyc.size();
        @(negedge clk);
        stb[1]  = 1'b1;
        addr[1] = REG_INTENSITY;
        data[1] = 8'hA5;
        waitAcks(1, a0 + 4, 200, "t3_ack_wait");
        @(negedge clk);
        stb[1] = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("t3_ack_count", g_rx[1].ack_cyc.size() - a0, 5);
        checkOutput("t3_frame_count", g_rx[1].load_cyc.size() - l0, 5);
        if (g_rx[1].ack_cyc.size() - a0 >= 5 && g_rx[1].load_cyc.size() - l0 >= 5) begin
            for (int i = 0; i < 5; i++) begin
                if (i > 0)
                    checkOutput($sformatf("t3_ack_gap%0d", i),
                                g_rx[1].ack_cyc[a0 + i] - g_rx[1].ack_cyc[a0 + i - 1], 35);
                checkOutput($sformatf("t3_word%0d", i), g_rx[1].latched_q[l0 + i], 16'h0AA5);
                checkOutput($sformatf("t3_rises%0d", i),
                            g_rx[1].rises_at_load[l0 + i] -
                            ((i == 0) ? r0 : g_rx[1].rises_at_load[l0 + i - 1]), 16);
            end
        end

        // Reset in the middle of a frame, then a clean frame afterwards.
        applyStimulus(0, REG_DECODE, 8'hFF, e);
        repeat (20) @(negedge clk);
        checkOutput("t1_load_low_mid_frame", load[0], 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("t1_frame_reset_inst0", {busy[0], ack[0], load[0], sclk[0], dout[0]}, 5'b00100);
        @(negedge clk);
        rst = 1'b0;

        l0 = g_rx[0].load_cyc.size();
        a0 = g_rx[0].ack_cyc.size();
        applyStimulus(0, REG_SCAN_LIMIT, 8'h07, e);
        waitAcks(0, a0 + 1, 100, "t1_recover_ack_wait");
        repeat (3) @(negedge clk);
        if (g_rx[0].ack_cyc.size() > a0) checkOutput("t1_recover_ack_cycle", g_rx[0].ack_cyc[a0], e + 68);
        if (g_rx[0].load_cyc.size() > l0) checkOutput("t1_recover_word", g_rx[0].latched_q[l0], 16'h0B07);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
